data_mem_responder: RTL

Responder end of the CPU data-memory port. Accepts load/store requests from the core over a valid/ready request channel and holds them for a programmable number of wait states. It then returns a response over a valid/ready response channel. Stores are byte-lane merged into a word array; load data is extracted and sign- or zero-extended per RV64 rules. Replaces the single-cycle combinational data memory, so the core can run against realistic memory latency.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/data_mem_responder_if.sv | 29 ++
 rtl/mem_lane_align.sv | 50 +++++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and
// the default datapath width.
package mem_pkg;

  localparam int N_DEFAULT = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte-lane enable for an access of the given size starting at lane 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_B:    lane_mask = 8'h01;
      SZ_H:    lane_mask = 8'h03;
      SZ_W:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channels between the core (master) and the data-memory
// responder (slave).
interface data_mem_responder_if #(
  parameter int N = mem_pkg::N_DEFAULT
);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_rdata;
  logic         rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: merges store bytes into a word, extracts and
// extends load bytes, and flags accesses not aligned to their size.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [2:0]   offset,
  input  logic [1:0]   size,
  input  logic         is_unsigned,
  input  logic [N-1:0] old_word,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] wr_word,
  output logic [N-1:0] ld_data,
  output logic         misaligned
);

  logic [5:0]   sh_amt;
  logic [7:0]   byte_en;
  logic [N-1:0] wdata_sh;
  logic [N-1:0] rd_sh;

  always_comb begin
    sh_amt   = {offset, 3'b000};
    byte_en  = lane_mask(size) << offset;
    wdata_sh = wdata << sh_amt;
    rd_sh    = old_word >> sh_amt;

    wr_word = old_word;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) wr_word[8*i +: 8] = wdata_sh[8*i +: 8];
    end

    // Doubles fill the word, so the unsigned flag has no effect on them.
    case (size)
      SZ_B:    ld_data = {{(N-8){~is_unsigned & rd_sh[7]}}, rd_sh[7:0]};
      SZ_H:    ld_data = {{(N-16){~is_unsigned & rd_sh[15]}}, rd_sh[15:0]};
      SZ_W:    ld_data = {{(N-32){~is_unsigned & rd_sh[31]}}, rd_sh[31:0]};
      default: ld_data = rd_sh;
    endcase

    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = offset[0];
      SZ_W:    misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// commits to the word array on entry to RESP and holds the response until taken.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         req_ready_q, req_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_error_q, rsp_error_d;
  logic [N-1:0] rsp_rdata_q, rsp_rdata_d;

  logic         write_q, write_d;
  logic         unsigned_q, unsigned_d;
  logic [1:0]   size_q, size_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;

  logic             accept;
  logic             commit;
  logic             out_of_range;
  logic             misaligned;
  logic             acc_error;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     old_word, wr_word, ld_data;

  logic [N-1:0] mem [DEPTH];

  // In IDLE the *_d request fields follow the live inputs, so a zero-latency
  // access can commit on the acceptance edge; afterwards they hold the latch.
  always_comb begin
    accept     = (state_q == IDLE) && bus.req_valid;
    write_d    = accept ? bus.req_write    : write_q;
    unsigned_d = accept ? bus.req_unsigned : unsigned_q;
    size_d     = accept ? bus.req_size     : size_q;
    addr_d     = accept ? bus.req_addr     : addr_q;
    wdata_d    = accept ? bus.req_wdata    : wdata_q;

    idx          = addr_d[IDX_W+2:3];
    out_of_range = addr_d[N-1:3] >= (N-3)'(DEPTH);
    old_word     = mem[idx];
    acc_error    = out_of_range | misaligned;
  end

  mem_lane_align #(.N(N)) u_align (
    .offset      (addr_d[2:0]),
    .size        (size_d),
    .is_unsigned (unsigned_d),
    .old_word    (old_word),
    .wdata       (wdata_d),
    .wr_word     (wr_word),
    .ld_data     (ld_data),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    commit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = LAT;
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      rsp_error_d = acc_error;
      rsp_rdata_d = (acc_error || write_d) ? '0 : ld_data;
    end

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Request latch and array carry no reset; the array survives reset by design.
  always_ff @(posedge clk) begin
    write_q    <= write_d;
    unsigned_q <= unsigned_d;
    size_q     <= size_d;
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    if (commit && write_d && !acc_error) mem[idx] <= wr_word;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule
